// File: rtl/tpg_pkg.sv
// Shared types and defaults for the pseudo-random test-pattern source.
package tpg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StValid,
    StDone
  } tpg_state_e;

  localparam int unsigned TpgVecW  = 157;
  localparam int unsigned TpgLfsrW = 32;
  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] TpgPoly  = 32'h80200003;

  function automatic int unsigned nwords(input int unsigned vec_w, input int unsigned lfsr_w);
    return (vec_w + lfsr_w - 1) / lfsr_w;
  endfunction

endpackage

// File: rtl/tpg_lfsr_step.sv
// Combinational Galois LFSR next-state; also intended for the downstream MISR.
module tpg_lfsr_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] lfsr_i,
  input  logic [Width-1:0] poly_i,
  output logic [Width-1:0] next_o
);

  always_comb begin
    next_o = (lfsr_i >> 1) ^ (lfsr_i[0] ? poly_i : '0);
  end

endmodule

// File: rtl/tpg_lfsr_source.sv
// LFSR test-pattern source: assembles VEC_W-bit vectors word by word and hands them
// out over valid/ready until a vector budget runs out. TPG_WEIGHTED_EN adds weight_sel.
module tpg_lfsr_source
  import tpg_pkg::*;
#(
  parameter int unsigned       VEC_W  = TpgVecW,
  parameter int unsigned       LFSR_W = TpgLfsrW,
  parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(TpgPoly),
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  max_vec,
`ifdef TPG_WEIGHTED_EN
  input  logic [1:0]        weight_sel,
`endif
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [VEC_W-1:0]  vec_data,
  output logic [CNT_W-1:0]  vec_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NWords = nwords(VEC_W, LFSR_W);
  localparam int unsigned FillW  = $clog2(2 * NWords);
  localparam int unsigned LastW  = VEC_W - (NWords - 1) * LFSR_W;

  tpg_state_e        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [VEC_W-1:0]  vec_data_q, vec_data_d;
  logic [CNT_W-1:0]  vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic [FillW-1:0]  fill_cnt_q, fill_cnt_d;
  logic              start_ok, fill_step, fill_last, word_we;
  logic [FillW-1:0]  word_sel;
  logic [LFSR_W-1:0] word_val;

  tpg_lfsr_step #(
    .Width (LFSR_W)
  ) u_step (
    .lfsr_i (lfsr_q),
    .poly_i (POLY),
    .next_o (lfsr_next)
  );

  assign start_ok = (state_q == StIdle || state_q == StDone) && start && !abort;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    vec_idx_d  = vec_idx_q;
    budget_d   = budget_q;
    fill_cnt_d = fill_cnt_q;
    fill_step  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // A zero seed would lock the LFSR up, so it is replaced by 1.
        if (seed_load) lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
        if (start) begin
          state_d    = StFill;
          vec_idx_d  = '0;
          budget_d   = max_vec;
          fill_cnt_d = '0;
        end
      end
      StFill: begin
        fill_step  = 1'b1;
        lfsr_d     = lfsr_next;
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_last) state_d = StValid;
      end
      StValid: begin
        if (vec_ready) begin
          vec_idx_d  = vec_idx_q + 1'b1;
          fill_cnt_d = '0;
          state_d    = (budget_q != '0 && vec_idx_d == budget_q) ? StDone : StFill;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d   = StIdle;
      lfsr_d    = lfsr_q;
      vec_idx_d = vec_idx_q;
      fill_step = 1'b0;
    end
  end

`ifdef TPG_WEIGHTED_EN
  logic [1:0]        wsel_q, wsel_d;
  logic [LFSR_W-1:0] tmp_q, tmp_d;
  logic              weighted;

  assign weighted = (wsel_q == 2'd1) || (wsel_q == 2'd2);

  // Weighted modes spend two fill cycles per word: even cycle latches, odd cycle combines.
  always_comb begin
    wsel_d = start_ok ? weight_sel : wsel_q;
    tmp_d  = tmp_q;
    if (fill_step && !fill_cnt_q[0]) tmp_d = lfsr_q;
    if (weighted) begin
      fill_last = (fill_cnt_q == FillW'(2 * NWords - 1));
      word_sel  = fill_cnt_q >> 1;
      word_we   = fill_step && fill_cnt_q[0];
      word_val  = (wsel_q == 2'd1) ? (tmp_q & lfsr_q) : (tmp_q | lfsr_q);
    end else begin
      fill_last = (fill_cnt_q == FillW'(NWords - 1));
      word_sel  = fill_cnt_q;
      word_we   = fill_step;
      word_val  = lfsr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel_q <= 2'd0;
      tmp_q  <= '0;
    end else begin
      wsel_q <= wsel_d;
      tmp_q  <= tmp_d;
    end
  end
`else
  always_comb begin
    fill_last = (fill_cnt_q == FillW'(NWords - 1));
    word_sel  = fill_cnt_q;
    word_we   = fill_step;
    word_val  = lfsr_q;
  end
`endif

  // The top word keeps only the low LastW bits of its LFSR word.
  for (genvar k = 0; k < NWords; k++) begin : g_word
    localparam int unsigned Lo = k * LFSR_W;
    localparam int unsigned Wd = (k == NWords - 1) ? LastW : LFSR_W;
    assign vec_data_d[Lo +: Wd] = (word_we && word_sel == FillW'(k)) ? word_val[Wd-1:0]
                                                                      : vec_data_q[Lo +: Wd];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= LFSR_W'(1);
      vec_data_q <= '0;
      vec_idx_q  <= '0;
      budget_q   <= '0;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      vec_data_q <= vec_data_d;
      vec_idx_q  <= vec_idx_d;
      budget_q   <= budget_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign vec_valid = (state_q == StValid);
  assign busy      = (state_q == StFill) || (state_q == StValid);
  assign done      = (state_q == StDone);
  assign vec_data  = vec_data_q;
  assign vec_idx   = vec_idx_q;

endmodule
